// File: rtl/lbus_slave_if_if.sv
// rtl/lbus_slave_if_if.sv - user register bus between the local-bus responder and user logic
interface lbus_slave_if_if;
  logic        usr_wr_en;
  logic        usr_rd_req;
  logic [11:0] usr_addr;
  logic [15:0] usr_wdata;
  logic [15:0] usr_rd_data;
  logic        usr_rd_ack;

  // Responder side: issues write strobes and read requests
  modport master (
    output usr_wr_en,
    output usr_rd_req,
    output usr_addr,
    output usr_wdata,
    input  usr_rd_data,
    input  usr_rd_ack
  );

  // User register side: consumes strobes, answers read requests
  modport slave (
    input  usr_wr_en,
    input  usr_rd_req,
    input  usr_addr,
    input  usr_wdata,
    output usr_rd_data,
    output usr_rd_ack
  );
endinterface

// File: rtl/lbus_slave_if.sv
// rtl/lbus_slave_if.sv - asynchronous CPU local-bus responder with common registers and user bus bridge
module lbus_slave_if #(
  parameter logic [15:0] FPGA_VER     = 16'h0001,
  parameter int          RD_TIMEOUT   = 16,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [11:0]    lbus_addr,
  inout  wire  [15:0]    lbus_data,
  input  logic           lbus_cs_n,
  input  logic           lbus_oe_n,
  input  logic           lbus_we_n,
  output logic           lbus_wait_n,
  output logic [15:0]    led_ctrl,
  output logic [2:0]     gtp_loopback,
  output logic [7:0]     rd_timeout_cnt,
  lbus_slave_if_if.master ubus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR       = 3'd1,
    RD_LOC   = 3'd2,
    RD_EXT   = 3'd3,
    RD_HOLD  = 3'd4,
    WAIT_END = 3'd5
  } state_t;

  localparam logic [15:0] TO_LIMIT  = 16'(RD_TIMEOUT);
  localparam logic [11:0] USR_BASE  = 12'h100;

  state_t      state;
  state_t      state_nx;

  // Two-stage synchronizers for the asynchronous strobes
  logic        cs_s1, cs_s2;
  logic        oe_s1, oe_s2;
  logic        we_s1, we_s2;

  // Set once cs_n has been seen high, so each access is taken only once
  logic        armed;

  logic        wr_start;
  logic        rd_start;
  logic        pin_ext;
  logic        accept;
  logic        ack_hit;
  logic        to_hit;
  logic        rd_busy;
  logic        rd_busy_nx;
  logic        bus_drive;

  logic [11:0] addr_reg;
  logic [15:0] wdata_reg;
  logic [15:0] data_reg;
  logic [15:0] ebi_test;
  logic [15:0] ext_cnt;
  logic [15:0] rd_mux;

  assign wr_start   = armed && !cs_s2 && !we_s2;
  assign rd_start   = armed && !cs_s2 && !oe_s2 && we_s2;
  assign pin_ext    = (lbus_addr >= USR_BASE);
  assign accept     = (state == IDLE) && (state_nx != IDLE);
  assign ack_hit    = (state == RD_EXT) && ubus.usr_rd_ack;
  assign to_hit     = (state == RD_EXT) && !ubus.usr_rd_ack && (ext_cnt == TO_LIMIT);
  assign rd_busy    = (state == RD_LOC) || (state == RD_EXT);
  assign rd_busy_nx = (state_nx == RD_LOC) || (state_nx == RD_EXT);

  // Raw pins gate the driver so the bus is released as soon as the CPU ends the cycle
  assign bus_drive  = (rd_busy || (state == RD_HOLD)) && !lbus_cs_n && !lbus_oe_n;
  assign lbus_data  = bus_drive ? data_reg : 16'hzzzz;

  // Strobe synchronizers, idle-high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_s1 <= 1'b1;
      cs_s2 <= 1'b1;
      oe_s1 <= 1'b1;
      oe_s2 <= 1'b1;
      we_s1 <= 1'b1;
      we_s2 <= 1'b1;
    end else begin
      cs_s1 <= lbus_cs_n;
      cs_s2 <= cs_s1;
      oe_s1 <= lbus_oe_n;
      oe_s2 <= oe_s1;
      we_s1 <= lbus_we_n;
      we_s2 <= we_s1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // FSM next state; a write wins when we_n and oe_n are both low
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (wr_start) begin
          state_nx = WR;
        end else if (rd_start) begin
          state_nx = pin_ext ? RD_EXT : RD_LOC;
        end
      end
      WR:       state_nx = WAIT_END;
      RD_LOC:   state_nx = RD_HOLD;
      RD_EXT: begin
        if (ubus.usr_rd_ack || (ext_cnt == TO_LIMIT)) begin
          state_nx = RD_HOLD;
        end
      end
      RD_HOLD: begin
        if (cs_s2 || oe_s2) begin
          state_nx = IDLE;
        end
      end
      WAIT_END: begin
        if (cs_s2) begin
          state_nx = IDLE;
        end
      end
      default:  state_nx = IDLE;
    endcase
  end

  // Re-arm detection only after chip select has been seen released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b1;
    end else if (accept) begin
      armed <= 1'b0;
    end else if (cs_s2) begin
      armed <= 1'b1;
    end
  end

  // Wait stays low through the read states and one extra cycle so data is settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lbus_wait_n <= 1'b1;
    end else begin
      lbus_wait_n <= !(rd_busy || rd_busy_nx);
    end
  end

  // Capture address/data on detection and drive the user bus strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg        <= 12'h000;
      wdata_reg       <= 16'h0000;
      ubus.usr_wr_en  <= 1'b0;
      ubus.usr_rd_req <= 1'b0;
      ubus.usr_addr   <= 12'h000;
      ubus.usr_wdata  <= 16'h0000;
    end else begin
      ubus.usr_wr_en  <= accept && (state_nx == WR) && pin_ext;
      ubus.usr_rd_req <= accept && (state_nx == RD_EXT);
      if (accept) begin
        addr_reg  <= lbus_addr;
        wdata_reg <= lbus_data;
        if (pin_ext) begin
          ubus.usr_addr <= lbus_addr;
          if (state_nx == WR) begin
            ubus.usr_wdata <= lbus_data;
          end
        end
      end
    end
  end

  // Local register writes, one cycle after detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ebi_test     <= 16'h0000;
      led_ctrl     <= 16'h0000;
      gtp_loopback <= 3'b000;
    end else if (state == WR) begin
      case (addr_reg)
        12'h002: ebi_test     <= wdata_reg;
        12'h003: led_ctrl     <= wdata_reg;
        12'h004: gtp_loopback <= wdata_reg[2:0];
        default: ;
      endcase
    end
  end

  // Local read mux; unmapped addresses read as zero
  always_comb begin
    rd_mux = 16'h0000;
    case (addr_reg)
      12'h001: rd_mux = FPGA_VER;
      12'h002: rd_mux = ~ebi_test;
      12'h003: rd_mux = led_ctrl;
      12'h004: rd_mux = {13'b0, gtp_loopback};
      default: rd_mux = 16'h0000;
    endcase
  end

  // Cycles since the user read request; cleared whenever a new access is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_cnt <= 16'h0000;
    end else if (state == IDLE) begin
      ext_cnt <= 16'h0000;
    end else if (state == RD_EXT) begin
      ext_cnt <= ext_cnt + 16'h0001;
    end
  end

  // Saturating count of user reads that never got an acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_timeout_cnt <= 8'h00;
    end else if (to_hit && (rd_timeout_cnt != 8'hFF)) begin
      rd_timeout_cnt <= rd_timeout_cnt + 8'h01;
    end
  end

  // Read data register; pure datapath, only meaningful while a read is driven
  always_ff @(posedge clk) begin
    if (state == RD_LOC) begin
      data_reg <= rd_mux;
    end else if (ack_hit) begin
      data_reg <= ubus.usr_rd_data;
    end else if (to_hit) begin
      data_reg <= TIMEOUT_DATA;
    end
  end

endmodule

// File: tb/tb_lbus_slave_if.sv
// tb/tb_lbus_slave_if.sv - scoreboard bench for the local-bus responder
module tb_lbus_slave_if;

  typedef struct {
    logic [15:0] data;
    int          low;
  } rd_exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] lbus_addr = 12'h000;
  wire  [15:0] lbus_data;
  logic        cs_n = 1'b1;
  logic        oe_n = 1'b1;
  logic        we_n = 1'b1;
  logic        lbus_wait_n;
  logic [15:0] led_ctrl;
  logic [2:0]  gtp_loopback;
  logic [7:0]  rd_timeout_cnt;

  logic        cpu_drive = 1'b0;
  logic [15:0] cpu_wdata = 16'h0000;
  assign lbus_data = cpu_drive ? cpu_wdata : 16'hzzzz;

  int n_cmp = 0;
  int n_fail = 0;

  rd_exp_t     rd_q[$];
  wr_exp_t     wr_q[$];
  logic [11:0] req_q[$];

  int          wr_seen = 0;
  int          req_seen = 0;
  int          low_cnt = 0;
  logic        prev_wait = 1'b1;
  rd_exp_t     rd_e;
  wr_exp_t     wr_e;
  logic [11:0] req_e;

  bit          ack_en = 1'b0;
  int          ack_delay = 0;
  logic [15:0] ack_data = 16'h0000;

  lbus_slave_if_if ubus ();

  lbus_slave_if #(
    .FPGA_VER     (16'h0001),
    .RD_TIMEOUT   (16),
    .TIMEOUT_DATA (16'hDEAD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lbus_addr      (lbus_addr),
    .lbus_data      (lbus_data),
    .lbus_cs_n      (cs_n),
    .lbus_oe_n      (oe_n),
    .lbus_we_n      (we_n),
    .lbus_wait_n    (lbus_wait_n),
    .led_ctrl       (led_ctrl),
    .gtp_loopback   (gtp_loopback),
    .rd_timeout_cnt (rd_timeout_cnt),
    .ubus           (ubus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // User-side responder: acks each request after ack_delay cycles when enabled
  initial begin
    ubus.usr_rd_ack  = 1'b0;
    ubus.usr_rd_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (ubus.usr_rd_req && ack_en) begin
        repeat (ack_delay) @(negedge clk);
        ubus.usr_rd_data = ack_data;
        ubus.usr_rd_ack  = 1'b1;
        @(negedge clk);
        ubus.usr_rd_ack  = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or completes a read
  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt   = 0;
      prev_wait = 1'b1;
    end else begin
      if (ubus.usr_wr_en) begin
        wr_seen++;
        if (wr_q.size() == 0) begin
          check("unexpected_usr_wr_en", 32'(1), 32'(0));
        end else begin
          wr_e = wr_q.pop_front();
          check("usr_wr_addr", 32'(ubus.usr_addr), 32'(wr_e.addr));
          check("usr_wr_data", 32'(ubus.usr_wdata), 32'(wr_e.data));
        end
      end
      if (ubus.usr_rd_req) begin
        req_seen++;
        if (req_q.size() == 0) begin
          check("unexpected_usr_rd_req", 32'(1), 32'(0));
        end else begin
          req_e = req_q.pop_front();
          check("usr_rd_addr", 32'(ubus.usr_addr), 32'(req_e));
        end
      end
      if (!lbus_wait_n) begin
        low_cnt++;
      end else if (!prev_wait) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read_done", 32'(1), 32'(0));
        end else begin
          rd_e = rd_q.pop_front();
          check("read_data", 32'(lbus_data), 32'(rd_e.data));
          check("wait_low_clks", 32'(low_cnt), 32'(rd_e.low));
        end
        low_cnt = 0;
      end
      prev_wait = lbus_wait_n;
    end
  end

  task automatic cpu_write(input logic [11:0] a, input logic [15:0] d, input bit to_usr);
    if (to_usr) wr_q.push_back('{addr: a, data: d});
    @(negedge clk);
    lbus_addr = a;
    cpu_wdata = d;
    cpu_drive = 1'b1;
    cs_n = 1'b0;
    we_n = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    we_n = 1'b1;
    cpu_drive = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cpu_read(input logic [11:0] a, input logic [15:0] exp_d, input int exp_low, input bit ext);
    bit seen_low;
    bit done;
    rd_q.push_back('{data: exp_d, low: exp_low});
    if (ext) req_q.push_back(a);
    @(negedge clk);
    lbus_addr = a;
    cs_n = 1'b0;
    oe_n = 1'b0;
    seen_low = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (!lbus_wait_n) seen_low = 1'b1;
      else if (seen_low) done = 1'b1;
    end
    check("read_completes", 32'(done), 32'(1));
    @(negedge clk);
    cs_n = 1'b1;
    oe_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit got_low;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_wait_n", 32'(lbus_wait_n), 32'(1));
    check("rst_led_ctrl", 32'(led_ctrl), 32'(0));
    check("rst_gtp_loopback", 32'(gtp_loopback), 32'(0));
    check("rst_usr_wr_en", 32'(ubus.usr_wr_en), 32'(0));
    check("rst_usr_rd_req", 32'(ubus.usr_rd_req), 32'(0));
    check("rst_usr_addr", 32'(ubus.usr_addr), 32'(0));
    check("rst_usr_wdata", 32'(ubus.usr_wdata), 32'(0));
    check("rst_timeout_cnt", 32'(rd_timeout_cnt), 32'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // EBI scratch test and version register
    cpu_write(12'h002, 16'h5A5A, 1'b0);
    cpu_read(12'h002, 16'hA5A5, 2, 1'b0);
    cpu_read(12'h001, 16'h0001, 2, 1'b0);

    // LED and GTP loopback registers
    cpu_write(12'h003, 16'h00F0, 1'b0);
    cpu_write(12'h004, 16'h0005, 1'b0);
    check("led_ctrl", 32'(led_ctrl), 32'(16'h00F0));
    check("gtp_loopback", 32'(gtp_loopback), 32'(3'b101));
    cpu_read(12'h003, 16'h00F0, 2, 1'b0);
    cpu_read(12'h004, 16'h0005, 2, 1'b0);

    // Ten user writes, then ignored writes to read-only and unmapped space
    for (int i = 0; i < 10; i++) cpu_write(12'h100, 16'h8000, 1'b1);
    cpu_write(12'h001, 16'h1234, 1'b0);
    cpu_write(12'h050, 16'h4321, 1'b0);
    cpu_read(12'h001, 16'h0001, 2, 1'b0);
    cpu_read(12'h050, 16'h0000, 2, 1'b0);
    check("usr_wr_en_pulses", 32'(wr_seen), 32'(10));

    // User read acknowledged five cycles after the request
    ack_en = 1'b1;
    ack_delay = 5;
    ack_data = 16'h1234;
    cpu_read(12'h105, 16'h1234, 7, 1'b1);

    // User read that times out; its ack arrives only after the access is over
    ack_delay = 25;
    ack_data = 16'hBEEF;
    cpu_read(12'h105, 16'hDEAD, 18, 1'b1);
    check("timeout_cnt_after_to", 32'(rd_timeout_cnt), 32'(1));
    repeat (10) @(negedge clk);
    check("timeout_cnt_late_ack", 32'(rd_timeout_cnt), 32'(1));
    cpu_read(12'h003, 16'h00F0, 2, 1'b0);

    // Reset in the middle of an unanswered user read
    ack_en = 1'b0;
    req_q.push_back(12'h105);
    @(negedge clk);
    lbus_addr = 12'h105;
    cs_n = 1'b0;
    oe_n = 1'b0;
    got_low = 1'b0;
    for (int i = 0; i < 20 && !got_low; i++) begin
      @(negedge clk);
      if (!lbus_wait_n) got_low = 1'b1;
    end
    check("rst_mid_wait_low", 32'(lbus_wait_n), 32'(0));
    @(negedge clk);
    check("rst_mid_bus_driven", 32'(lbus_data), 32'(16'h00F0));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_wait_n", 32'(lbus_wait_n), 32'(1));
    check("rst_mid_bus_released", 32'(lbus_data !== 16'h00F0), 32'(1));
    check("rst_mid_led_ctrl", 32'(led_ctrl), 32'(0));
    check("rst_mid_timeout_cnt", 32'(rd_timeout_cnt), 32'(0));
    @(negedge clk);
    cs_n = 1'b1;
    oe_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cpu_read(12'h002, 16'hFFFF, 2, 1'b0);

    // Everything issued must have been observed
    repeat (5) @(negedge clk);
    check("rd_queue_empty", 32'(rd_q.size()), 32'(0));
    check("wr_queue_empty", 32'(wr_q.size()), 32'(0));
    check("req_queue_empty", 32'(req_q.size()), 32'(0));
    check("usr_wr_en_total", 32'(wr_seen), 32'(10));
    check("usr_rd_req_total", 32'(req_seen), 32'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
